// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store data.
// Data has priority; a saturating streak counter bounds how long fetch can be starved.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ack,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    owner_d_r;
    logic [3:0]              streak_r;
    logic [3:0]              streak_s;
    logic                    grant_d_s;
    logic                    grant_i_s;
    logic                    done_s;
    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic [STRB_WIDTH-1:0]   mem_wstrb_r;
    logic                    if_ack_r;
    logic                    d_ack_r;
    logic [DATA_WIDTH-1:0]   if_rdata_r;
    logic [DATA_WIDTH-1:0]   d_rdata_r;
    logic                    busy_r;

    // Next-state, grant decision and streak update
    always_comb begin
        state_s   = state_r;
        streak_s  = streak_r;
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req && (!if_req || (streak_r < STREAK_LIM))) begin
                    grant_d_s = 1'b1;
                    state_s   = BUSY;
                    if (if_req) begin
                        streak_s = (streak_r >= STREAK_LIM) ? STREAK_LIM : (streak_r + 4'd1);
                    end else begin
                        streak_s = 4'd0;
                    end
                end else if (if_req) begin
                    grant_i_s = 1'b1;
                    state_s   = BUSY;
                    streak_s  = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    done_s  = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                // Requests still high here belong to the finished transfer; only IDLE re-arbitrates.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched transfer fields and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            owner_d_r   <= 1'b0;
            streak_r    <= 4'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
            if_ack_r    <= 1'b0;
            d_ack_r     <= 1'b0;
            if_rdata_r  <= '0;
            d_rdata_r   <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            streak_r  <= streak_s;
            busy_r    <= (state_s != IDLE);
            mem_req_r <= (state_s == BUSY);
            if_ack_r  <= done_s && !owner_d_r;
            d_ack_r   <= done_s && owner_d_r;
            if (grant_d_s) begin
                owner_d_r   <= 1'b1;
                mem_we_r    <= d_we;
                mem_addr_r  <= d_addr;
                mem_wdata_r <= d_wdata;
                mem_wstrb_r <= d_we ? d_wstrb : '0;
            end else if (grant_i_s) begin
                owner_d_r   <= 1'b0;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= if_addr;
                mem_wdata_r <= '0;
                mem_wstrb_r <= '0;
            end
            // Stores complete without touching d_rdata
            if (done_s && owner_d_r && !mem_we_r) begin
                d_rdata_r <= mem_rdata;
            end else if (done_s && !owner_d_r) begin
                if_rdata_r <= mem_rdata;
            end
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign if_ack    = if_ack_r;
    assign d_ack     = d_ack_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected transfers, checked at mem_req start and at each ack.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STREAK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_ack = -100;
    int   n_acks   = 0;
    logic prev_mem_req = 1'b0;
    logic mem_auto = 1'b0;
    int   mem_wait = 0;
    int   wcnt     = 0;

    function automatic logic [31:0] rd_for(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] a, input logic we,
                        input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] rd);
        txn_t t;
        t.is_d = is_d; t.addr = a; t.we = we; t.wstrb = strb; t.wdata = wd; t.rdata = rd;
        sb.push_back(t);
    endtask

    // One clock: sample outputs after the edge, score them, then play the memory side.
    task automatic tick();
        txn_t t;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_req && !prev_mem_req && sb.size() > 0) begin
            t = sb[0];
            chk("mem_addr", mem_addr, t.addr);
            chk("mem_we", 32'(mem_we), 32'(t.we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(t.wstrb));
            if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
        end
        prev_mem_req = mem_req;
        if (if_ack || d_ack) begin
            n_acks++;
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_ack observed if_ack=%0b d_ack=%0b expected none", if_ack, d_ack);
            end
            if (sb.size() > 0) begin
                t = sb.pop_front();
                chk("ack_port_d", 32'(d_ack), 32'(t.is_d));
                chk("ack_port_i", 32'(if_ack), 32'(!t.is_d));
                if (!t.we) chk(t.is_d ? "d_rdata" : "if_rdata", t.is_d ? d_rdata : if_rdata, t.rdata);
                chk("ack_gap_ge3", 32'((cyc - last_ack) >= 3), 32'd1);
            end
            last_ack = cyc;
        end
        if (mem_auto) begin
            if (mem_req) begin
                if (wcnt == mem_wait) begin
                    mem_ack = 1'b1; mem_rdata = rd_for(mem_addr); wcnt = 0;
                end else begin
                    mem_ack = 1'b0; wcnt++;
                end
            end else begin
                mem_ack = 1'b0; wcnt = 0;
            end
        end
    endtask

    task automatic wait_ack(input logic is_d, input string tag, output int at);
        at = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (is_d ? d_ack : if_ack) begin
                at = cyc;
                break;
            end
        end
        n_assert++;
        assert (at >= 0) else begin
            n_fail++;
            $error("FAIL %s observed=no ack expected=ack within 64 cycles", tag);
        end
    endtask

    initial begin
        int c, a1, a2;
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        if_addr = 32'h0000_0500; d_we = 1'b1; d_addr = 32'h0000_0300;
        d_wdata = 32'h1234_5678; d_wstrb = 4'hF;

        // Reset with requests and a stray mem_ack present
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
            chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0; mem_auto = 1'b1;
        tick();
        chk("idle_mem_req", 32'(mem_req), 32'd0);

        // Zero-wait fetch
        mem_wait = 0;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        push(1'b0, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0050_0093);
        c = cyc;
        tick();
        chk("f_busy1", 32'(busy), 32'd1);
        chk("f_mem_req1", 32'(mem_req), 32'd1);
        tick();
        chk("f_ack_cycle", 32'(cyc - c), 32'd2);
        chk("f_if_ack", 32'(if_ack), 32'd1);
        chk("f_busy2", 32'(busy), 32'd1);
        chk("f_mem_req_drop", 32'(mem_req), 32'd0);
        chk("f_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        tick();
        chk("f_ack_pulse", 32'(if_ack), 32'd0);
        chk("f_busy_end", 32'(busy), 32'd0);

        // Store with three wait states; fields must stay latched
        mem_wait = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        push(1'b1, 32'h0000_0200, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s_mem_req", 32'(mem_req), 32'd1);
            chk("s_mem_addr", mem_addr, 32'h0000_0200);
            chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("s_mem_wstrb", 32'(mem_wstrb), 32'h3);
            chk("s_mem_we", 32'(mem_we), 32'd1);
            chk("s_no_ack", 32'(d_ack), 32'd0);
            if (i == 0) d_wdata = 32'h0;
        end
        tick();
        chk("s_d_ack", 32'(d_ack), 32'd1);
        chk("s_d_rdata_kept", d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("s_ack_pulse", 32'(d_ack), 32'd0);

        // Priority and streak: both held high
        mem_wait = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_wstrb = 4'hF;
        if_req = 1'b1; if_addr = 32'h0000_0500;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) push(1'b0, 32'h0000_0500, 1'b0, 4'h0, 32'h0, rd_for(32'h0000_0500));
            else              push(1'b1, 32'h0000_0300, 1'b0, 4'h0, 32'h0, rd_for(32'h0000_0300));
        end
        n_acks = 0;
        for (int i = 0; i < 100 && n_acks < 10; i++) tick();
        d_req = 1'b0; if_req = 1'b0;
        chk("p_ack_count", 32'(n_acks), 32'd10);
        chk("p_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Reset in the second BUSY cycle, late mem_ack afterwards
        mem_auto = 1'b0; mem_ack = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        tick();
        chk("r_mem_req", 32'(mem_req), 32'd1);
        tick();
        chk("r_busy2", 32'(busy), 32'd1);
        rst = 1'b1; d_req = 1'b0;
        tick();
        chk("r_mem_req_drop", 32'(mem_req), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_d_rdata", d_rdata, 32'd0);
        chk("r_if_rdata", if_rdata, 32'd0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        chk("r_late_no_ack", 32'({if_ack, d_ack}), 32'd0);
        chk("r_late_no_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        tick();
        chk("r_late_d_ack", 32'(d_ack), 32'd0);
        chk("r_late_d_rdata", d_rdata, 32'd0);
        chk("r_late_busy", 32'(busy), 32'd0);
        mem_auto = 1'b1;

        // Back-to-back fetch with req held
        if_req = 1'b1; if_addr = 32'h0000_0000;
        push(1'b0, 32'h0000_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0011);
        push(1'b0, 32'h0000_0004, 1'b0, 4'h0, 32'h0, 32'h0000_0022);
        c = cyc;
        wait_ack(1'b0, "b2b_first", a1);
        chk("b_first_latency", 32'(a1 - c), 32'd2);
        chk("b_rdata1", if_rdata, 32'h0000_0011);
        if_addr = 32'h0000_0004;
        wait_ack(1'b0, "b2b_second", a2);
        if_req = 1'b0;
        chk("b_spacing", 32'(a2 - a1), 32'd3);
        chk("b_rdata2", if_rdata, 32'h0000_0022);
        tick();
        tick();
        chk("b_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
